sumador_serial: RTL

Bit-serial unsigned adder for the ALU. It is the additive counterpart of the magnitude subtractor.
- Latches two WIDTH-bit operands on an init request.
- Adds them one bit per clock through a single full adder and carry flip-flop.
- Presents a 2*WIDTH-bit zero-extended sum with a one-cycle done pulse.
- Sits beside the other ALU operation units and shares the same init/operand/result port style.

---
 rtl/sumador_serial.sv | 106 ++++++++++
 1 files changed

// File: rtl/sumador_serial.sv
// Bit-serial unsigned adder: one full adder plus carry flop,
// one operand bit per clock, zero-extended 2*WIDTH-bit result.
module sumador_serial #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic [WIDTH-1:0]   portA,
  input  logic [WIDTH-1:0]   portB,
  output logic [2*WIDTH-1:0] suma,
  output logic               busy,
  output logic               done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [WIDTH-1:0]  areg;
  logic [WIDTH-1:0]  breg;
  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  acc_nx;
  logic [CW-1:0]     cnt;
  logic              carry;
  logic              cy_nx;
  logic              s;
  logic              last;

  always_comb begin
    s      = areg[0] ^ breg[0] ^ carry;
    cy_nx  = (areg[0] & breg[0]) |
             (areg[0] & carry) |
             (breg[0] & carry);
    acc_nx = acc;
    acc_nx[cnt] = s;
    last   = (cnt == CW'(WIDTH-1));
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (init) state_nx = ADD;
      end
      ADD: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      areg  <= '0;
      breg  <= '0;
      acc   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      suma  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (init) begin
            areg  <= portA;
            breg  <= portB;
            acc   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
          end
        end
        ADD: begin
          areg  <= areg >> 1;
          breg  <= breg >> 1;
          carry <= cy_nx;
          acc   <= acc_nx;
          cnt   <= cnt + 1'b1;
          // result is published only once, on the final bit
          if (last)
            suma <= {{(WIDTH-1){1'b0}}, cy_nx, acc_nx};
        end
        default: ;
      endcase
    end
  end

endmodule
